// File: rtl/nave_pkg.sv
// Shared definitions for the spaceship sprite blocks.
// Contents:
//   SpriteSize      - native sprite edge length in pixels (11)
//   nave_state_e    - animation state encoding (ALIVE/EXPLODE/DEAD/RESPAWN)
//   nave_img_e      - image selector for nave_sprite_rom
//   ShipBmp, ExplABmp, ExplBBmp - 11x11 bitmaps, one 11-bit word per row,
//                                 bit c of a row is column c.
package nave_pkg;

  localparam int unsigned SpriteSize = 11;

  typedef enum logic [1:0] {
    StAlive   = 2'd0,
    StExplode = 2'd1,
    StDead    = 2'd2,
    StRespawn = 2'd3
  } nave_state_e;

  typedef enum logic [1:0] {
    ImgNone  = 2'd0,
    ImgShip  = 2'd1,
    ImgExplA = 2'd2,
    ImgExplB = 2'd3
  } nave_img_e;

  // Row 0 is listed first; all three images are left/right symmetric.
  localparam logic [0:10][10:0] ShipBmp = {
    11'b00000100000,
    11'b00001110000,
    11'b00011111000,
    11'b00111011100,
    11'b01110001110,
    11'b11111111111,
    11'b11111111111,
    11'b11111111111,
    11'b11111111111,
    11'b00100000100,
    11'b00100000100
  };

  // Both diagonals plus the centre row and column.
  localparam logic [0:10][10:0] ExplABmp = {
    11'b10000100001,
    11'b01000100010,
    11'b00100100100,
    11'b00010101000,
    11'b00001110000,
    11'b11111111111,
    11'b00001110000,
    11'b00010101000,
    11'b00100100100,
    11'b01000100010,
    11'b10000100001
  };

  // Border ring plus the centre 3x3 block.
  localparam logic [0:10][10:0] ExplBBmp = {
    11'b11111111111,
    11'b10000000001,
    11'b10000000001,
    11'b10000000001,
    11'b10001110001,
    11'b10001110001,
    11'b10001110001,
    11'b10000000001,
    11'b10000000001,
    11'b10000000001,
    11'b11111111111
  };

endpackage

// File: rtl/nave_sprite_rom.sv
// Combinational 11x11 sprite lookup.
// Ports:
//   img_sel_i - image selector (nave_img_e encoding)
//   oy_i      - row within the sprite, 0..10
//   ox_i      - column within the sprite, 0..10
//   lit_o     - pixel lit; 0 for ImgNone or coordinates outside 0..10
module nave_sprite_rom
  import nave_pkg::*;
(
  input  logic [1:0] img_sel_i,
  input  logic [3:0] oy_i,
  input  logic [3:0] ox_i,
  output logic       lit_o
);

  logic [10:0] row;
  logic [15:0] row_ext;

  always_comb begin
    row = '0;
    if (oy_i < 4'd11) begin
      unique case (nave_img_e'(img_sel_i))
        ImgNone:  row = '0;
        ImgShip:  row = ShipBmp[oy_i];
        ImgExplA: row = ExplABmp[oy_i];
        ImgExplB: row = ExplBBmp[oy_i];
        default:  row = '0;
      endcase
    end
    // Zero padding makes columns 11..15 read as unlit.
    row_ext = {5'b0, row};
    lit_o   = row_ext[ox_i];
  end

endmodule

// File: rtl/nave_sprite_anim.sv
// Spaceship sprite renderer with hit / explosion / respawn animation.
// The horizontal position is latched once per frame so motion never tears;
// pixel outputs are registered (one cycle after h_counter/v_counter).
// Ports:
//   clk, reset          - pixel clock, synchronous active-low reset
//   h_counter/v_counter - current pixel column / line
//   mem_X_barra         - requested ship left edge (clamped on latch)
//   hit                 - single-cycle collision pulse
//   R, G, B, pixel_on   - registered sprite colour and lit flag
//   state               - 0=ALIVE 1=EXPLODE 2=DEAD 3=RESPAWN
//   invuln              - high whenever state is not ALIVE
module nave_sprite_anim
  import nave_pkg::*;
#(
  parameter int unsigned SCALE_LOG2  = 0,
  parameter int unsigned START_Y     = 150,
  parameter int unsigned H_ACTIVE    = 640,
  parameter logic [23:0] SHIP_RGB    = 24'hFFFFFF,
  parameter logic [23:0] EXPL_RGB    = 24'hFF8000,
  parameter int unsigned EXPL_FRAMES = 8,
  parameter int unsigned EXPL_LEN    = 32,
  parameter int unsigned DEAD_LEN    = 60,
  parameter int unsigned RESP_LEN    = 120,
  parameter int unsigned BLINK_LOG2  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic [10:0] mem_X_barra,
  input  logic        hit,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic        pixel_on,
  output logic [1:0]  state,
  output logic        invuln
);

  localparam int unsigned W          = SpriteSize << SCALE_LOG2;
  localparam logic [10:0] XMax       = 11'(H_ACTIVE - W);
  localparam logic [10:0] WExt       = 11'(W);
  localparam logic [10:0] YTop       = 11'(START_Y);
  localparam logic [10:0] YEnd       = 11'(START_Y + W);
  localparam logic [7:0]  ExplLast   = 8'(EXPL_LEN - 1);
  localparam logic [7:0]  DeadLast   = 8'(DEAD_LEN - 1);
  localparam logic [7:0]  RespLast   = 8'(RESP_LEN - 1);
  localparam logic [7:0]  ExplFrames = 8'(EXPL_FRAMES);
  // Only the blink bit of the frame counter is ever observed, so the
  // counter is kept just wide enough to produce it.
  localparam int unsigned FrameW     = BLINK_LOG2 + 1;

  nave_state_e       state_q, state_d;
  logic [7:0]        phase_q, phase_d;
  logic              hit_pend_q, hit_pend_d;
  logic [10:0]       x_q, x_d;
  logic [FrameW-1:0] frame_q, frame_d;
  logic [7:0]        r_q, g_q, b_q;
  logic              pix_q;

  logic        fs;
  logic [10:0] h_ext, v_ext;
  logic        in_box;
  logic [3:0]  ox, oy;
  nave_img_e   img_sel;
  logic        lit;
  logic        pix_d;
  logic [23:0] rgb_d;

  assign fs = (h_counter == 10'd0) && (v_counter == 10'd0);

  // Frame-rate control: position latch, frame counter and animation FSM.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    hit_pend_d = hit_pend_q;
    x_d        = x_q;
    frame_d    = frame_q;

    // A hit is only remembered while the ship is vulnerable.
    if (hit && (state_q == StAlive)) begin
      hit_pend_d = 1'b1;
    end

    if (fs) begin
      x_d     = (mem_X_barra > XMax) ? XMax : mem_X_barra;
      frame_d = frame_q + 1'b1;
      phase_d = phase_q + 8'd1;
      unique case (state_q)
        StAlive: begin
          if (hit_pend_d) begin
            state_d    = StExplode;
            phase_d    = '0;
            hit_pend_d = 1'b0;
          end
        end
        StExplode: begin
          if (phase_q == ExplLast) begin
            state_d = StDead;
            phase_d = '0;
          end
        end
        StDead: begin
          if (phase_q == DeadLast) begin
            state_d = StRespawn;
            phase_d = '0;
          end
        end
        StRespawn: begin
          if (phase_q == RespLast) begin
            state_d = StAlive;
            phase_d = '0;
          end
        end
        default: state_d = StAlive;
      endcase
    end
  end

  // Pixel path: hit-box test, image selection and colour.
  always_comb begin
    h_ext  = {1'b0, h_counter};
    v_ext  = {1'b0, v_counter};
    in_box = (h_ext >= x_q) && (h_ext < x_q + WExt) && (v_ext >= YTop) && (v_ext < YEnd);
    ox     = 4'((h_ext - x_q) >> SCALE_LOG2);
    oy     = 4'((v_ext - YTop) >> SCALE_LOG2);

    img_sel = ImgNone;
    unique case (state_q)
      StAlive:   img_sel = ImgShip;
      StExplode: img_sel = (((phase_q / ExplFrames) & 8'd1) == 8'd0) ? ImgExplA : ImgExplB;
      StDead:    img_sel = ImgNone;
      StRespawn: img_sel = frame_q[BLINK_LOG2] ? ImgNone : ImgShip;
      default:   img_sel = ImgNone;
    endcase

    pix_d = in_box && lit;
    rgb_d = '0;
    if (pix_d) begin
      rgb_d = (img_sel == ImgShip) ? SHIP_RGB : EXPL_RGB;
    end
  end

  nave_sprite_rom u_rom (
    .img_sel_i (img_sel),
    .oy_i      (oy),
    .ox_i      (ox),
    .lit_o     (lit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= StAlive;
      phase_q    <= '0;
      hit_pend_q <= 1'b0;
      x_q        <= '0;
      frame_q    <= '0;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      pix_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      hit_pend_q <= hit_pend_d;
      x_q        <= x_d;
      frame_q    <= frame_d;
      r_q        <= rgb_d[23:16];
      g_q        <= rgb_d[15:8];
      b_q        <= rgb_d[7:0];
      pix_q      <= pix_d;
    end
  end

  assign R        = r_q;
  assign G        = g_q;
  assign B        = b_q;
  assign pixel_on = pix_q;
  assign state    = state_q;
  assign invuln   = (state_q != StAlive);

endmodule

// File: tb/tb_nave_sprite_anim.sv
// Randomised scoreboard bench for nave_sprite_anim. Two instances (scale 1x
// and 2x) share one stimulus stream; a frame-level reference model predicts
// every output cycle and a monitor compares one cycle later.
module tb_nave_sprite_anim;

  localparam int StartY   = 150;
  localparam int HActive  = 640;
  localparam int ExplLen  = 32;
  localparam int DeadLen  = 60;
  localparam int RespLen  = 120;
  localparam int AnimLen  = ExplLen + DeadLen + RespLen;
  localparam logic [23:0] ShipCol = 24'hFFFFFF;
  localparam logic [23:0] ExplCol = 24'hFF8000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  h_counter = 10'd1;
  logic [9:0]  v_counter = 10'd1;
  logic [10:0] mem_X_barra = 11'd100;
  logic        hit = 1'b0;

  logic [7:0] r0, g0, b0, r1, g1, b1;
  logic       pix0, pix1, inv0, inv1;
  logic [1:0] st0, st1;

  always #5 clk = ~clk;

  nave_sprite_anim u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .h_counter   (h_counter),
    .v_counter   (v_counter),
    .mem_X_barra (mem_X_barra),
    .hit         (hit),
    .R           (r0),
    .G           (g0),
    .B           (b0),
    .pixel_on    (pix0),
    .state       (st0),
    .invuln      (inv0)
  );

  nave_sprite_anim #(.SCALE_LOG2(1)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .h_counter   (h_counter),
    .v_counter   (v_counter),
    .mem_X_barra (mem_X_barra),
    .hit         (hit),
    .R           (r1),
    .G           (g1),
    .B           (b1),
    .pixel_on    (pix1),
    .state       (st1),
    .invuln      (inv1)
  );

  typedef struct {
    logic [23:0] rgb0;
    logic [23:0] rgb1;
    logic        pix0;
    logic        pix1;
    logic [1:0]  st;
    logic        inv;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model: latched X per instance, frames since reset, sticky hit,
  // and frames elapsed since the animation started (-1 while alive).
  int m_x0 = 0, m_x1 = 0, m_frames = 0, m_anim = -1;
  bit m_pend = 1'b0;

  function automatic bit ship_px(int r, int c);
    case (r)
      0:          return c == 5;
      1:          return c >= 4 && c <= 6;
      2:          return c >= 3 && c <= 7;
      3:          return (c >= 2 && c <= 4) || (c >= 6 && c <= 8);
      4:          return (c >= 1 && c <= 3) || (c >= 7 && c <= 9);
      5, 6, 7, 8: return 1'b1;
      default:    return c == 2 || c == 8;
    endcase
  endfunction

  function automatic bit expa_px(int r, int c);
    return r == c || r + c == 10 || r == 5 || c == 5;
  endfunction

  function automatic bit expb_px(int r, int c);
    return r == 0 || r == 10 || c == 0 || c == 10 || (r >= 4 && r <= 6 && c >= 4 && c <= 6);
  endfunction

  function automatic void model_pix(input int s, input int x, input int h, input int v,
                                    output logic [23:0] rgb, output logic on);
    int w, r, c;
    bit lit;
    logic [23:0] col;
    w   = 11 << s;
    rgb = '0;
    on  = 1'b0;
    if (h >= x && h < x + w && v >= StartY && v < StartY + w) begin
      c   = (h - x) >> s;
      r   = (v - StartY) >> s;
      lit = 1'b0;
      col = ShipCol;
      if (m_anim < 0) lit = ship_px(r, c);
      else if (m_anim < ExplLen) begin
        col = ExplCol;
        lit = (((m_anim / 8) % 2) == 0) ? expa_px(r, c) : expb_px(r, c);
      end else if (m_anim >= ExplLen + DeadLen) begin
        lit = (((m_frames >> 3) & 1) == 0) ? ship_px(r, c) : 1'b0;
      end
      if (lit) begin
        rgb = col;
        on  = 1'b1;
      end
    end
  endfunction

  function automatic int clamp_x(int req, int s);
    int lim;
    lim = HActive - (11 << s);
    return (req > lim) ? lim : req;
  endfunction

  function automatic logic [1:0] model_state(int anim);
    if (anim < 0) return 2'd0;
    if (anim < ExplLen) return 2'd1;
    if (anim < ExplLen + DeadLen) return 2'd2;
    return 2'd3;
  endfunction

  task automatic drive(input int h, input int v, input bit hit_b, input bit rst_n);
    exp_t e;
    @(negedge clk);
    reset     = rst_n;
    h_counter = 10'(h);
    v_counter = 10'(v);
    hit       = hit_b;
    if (!rst_n) begin
      m_x0 = 0; m_x1 = 0; m_frames = 0; m_anim = -1; m_pend = 1'b0;
      e.rgb0 = '0; e.rgb1 = '0; e.pix0 = 1'b0; e.pix1 = 1'b0;
    end else begin
      model_pix(0, m_x0, h, v, e.rgb0, e.pix0);
      model_pix(1, m_x1, h, v, e.rgb1, e.pix1);
      if (hit_b && m_anim < 0) m_pend = 1'b1;
      if (h == 0 && v == 0) begin
        m_frames++;
        m_x0 = clamp_x(int'(mem_X_barra), 0);
        m_x1 = clamp_x(int'(mem_X_barra), 1);
        if (m_anim < 0) begin
          if (m_pend) begin
            m_anim = 0;
            m_pend = 1'b0;
          end
        end else begin
          m_anim++;
          if (m_anim == AnimLen) m_anim = -1;
        end
      end
    end
    e.st  = model_state(m_anim);
    e.inv = (m_anim >= 0);
    sb_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: each output cycle answers the stimulus driven one edge earlier.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("rgb0", {8'd0, r0, g0, b0}, {8'd0, e.rgb0});
      chk("pix0", {31'd0, pix0}, {31'd0, e.pix0});
      chk("rgb1", {8'd0, r1, g1, b1}, {8'd0, e.rgb1});
      chk("pix1", {31'd0, pix1}, {31'd0, e.pix1});
      chk("state0", {30'd0, st0}, {30'd0, e.st});
      chk("state1", {30'd0, st1}, {30'd0, e.st});
      chk("invuln0", {31'd0, inv0}, {31'd0, e.inv});
      chk("invuln1", {31'd0, inv1}, {31'd0, e.inv});
    end
  end

  function automatic logic [10:0] new_x();
    case ($urandom_range(0, 5))
      0:       return 11'd100;
      1:       return 11'd300;
      2:       return 11'd700;
      3:       return 11'($urandom_range(0, 2047));
      4:       return 11'($urandom_range(600, 640));
      default: return 11'($urandom_range(0, 629));
    endcase
  endfunction

  function automatic int win_lo();
    int lo;
    lo = ((m_x0 < m_x1) ? m_x0 : m_x1) - 3;
    return (lo < 0) ? 0 : lo;
  endfunction

  function automatic int win_hi();
    int a, b;
    a = m_x0 + 14;
    b = m_x1 + 25;
    return (a > b) ? a : b;
  endfunction

  // Full raster over the sprite window; X request moves to 300 mid-frame.
  task automatic scan_frame();
    int lo, hi;
    drive(0, 0, 1'b0, 1'b1);
    lo = win_lo();
    hi = win_hi();
    for (int v = StartY - 4; v <= StartY + 26; v++) begin
      if (v == StartY + 10) mem_X_barra = 11'd300;
      for (int h = lo; h <= hi; h++) drive(h, v, 1'b0, 1'b1);
    end
  endtask

  // hit_mode: 0 none, 1 one mid-frame hit, 2 hits only while animating,
  //           3 hit on the frame-start cycle, 4 sparse hits anywhere.
  task automatic run_frame(input int n_px, input int hit_mode);
    int lo, hi, h, v, hit_at;
    bit hb;
    if ($urandom_range(0, 3) == 0) mem_X_barra = new_x();
    hit_at = $urandom_range(1, n_px);
    drive(0, 0, hit_mode == 3, 1'b1);
    lo = win_lo();
    hi = win_hi();
    for (int i = 1; i <= n_px; i++) begin
      if (i == n_px / 2 && $urandom_range(0, 3) == 0) mem_X_barra = new_x();
      if ($urandom_range(0, 3) == 0) begin
        h = $urandom_range(1, 1023);
        v = $urandom_range(0, 1023);
      end else begin
        h = $urandom_range(lo, hi);
        v = $urandom_range(StartY - 4, StartY + 26);
      end
      case (hit_mode)
        1:       hb = (i == hit_at);
        2:       hb = (m_anim >= 0) && ($urandom_range(0, 63) == 0);
        4:       hb = ($urandom_range(0, 199) == 0);
        default: hb = 1'b0;
      endcase
      drive(h, v, hb, 1'b1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive(5, 5, 1'b0, 1'b0);
    drive(5, 5, 1'b0, 1'b0);
    mem_X_barra = 11'd100;
    scan_frame();
    scan_frame();
    mem_X_barra = 11'd700;
    scan_frame();
    run_frame(120, 1);
    for (int f = 0; f < AnimLen + 6; f++) run_frame(120, 2);
    for (int f = 0; f < 10; f++) run_frame(80, 4);
    drive(7, 7, 1'b0, 1'b0);
    drive(7, 7, 1'b0, 1'b0);
    mem_X_barra = 11'd100;
    run_frame(60, 0);
    run_frame(60, 0);
    run_frame(60, 3);
    for (int f = 0; f < 3; f++) run_frame(120, 0);
    drive(105, StartY, 1'b0, 1'b1);
    drive(105, StartY, 1'b0, 1'b0);
    for (int h = 98; h < 114; h++) drive(h, StartY + 5, 1'b0, 1'b1);
    run_frame(120, 0);
    scan_frame();
    @(posedge clk);
    #3;
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
